// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem: AXI4 slave with independent single-outstanding write/read engines over a word-addressed RAM
module ei_axi4_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_DATA} rst_t;
  function automatic addr_t nxt(addr_t a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    addr_t bytes, span, low, inc;
    bytes = addr_t'(1) << size;
    span = bytes * (addr_t'(len) + addr_t'(1));
    low = a & ~(span - addr_t'(1));
    inc = a + bytes;
    return burst == 2'd0 ? a : burst == 2'd1 ? (a & ~(bytes - addr_t'(1))) + bytes : inc == low + span ? low : inc;
  endfunction
  // Whole-burst errors: unsupported size, reserved burst, malformed WRAP
  function automatic logic berr(addr_t a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    return int'(size) > LB || burst == 2'd3 || (burst == 2'd2 &&
      (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (a & ((addr_t'(1) << size) - addr_t'(1))) != '0));
  endfunction
  function automatic logic oob(addr_t a);
    return (a >> LB) >= addr_t'(MEM_WORDS);
  endfunction
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  wst_t ws, ws_n;
  rst_t rs, rs_n;
  addr_t waddr, raddr, rnext, rsel;
  logic [7:0] wlen, wbeat, rlen, rbeat;
  logic [2:0] wsize, rsize;
  logic [1:0] wburst, rburst;
  logic wbe, werr, rbe, rbad;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_en;
  logic [DATA_WIDTH-1:0] rd_word;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign b_hs = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs = rvalid && rready;
  assign w_en = w_hs && !wbe && !oob(waddr) && !areset;
  always_ff @(posedge aclk) ws <= areset ? W_IDLE : ws_n;
  always_comb ws_n = ws == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                     ws == W_DATA ? (w_hs && wbeat == wlen ? W_RESP : W_DATA) :
                     (b_hs ? W_IDLE : W_RESP);
  always_comb begin
    awready = ws == W_IDLE;
    wready = ws == W_DATA;
    bvalid = ws == W_RESP;
    bresp = {bvalid && werr, 1'b0};
  end
  // awlen governs the beat count; a misplaced wlast only flags the response
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      waddr <= awaddr;
      wlen <= awlen;
      wsize <= awsize;
      wburst <= awburst;
      wbeat <= '0;
      wbe <= berr(awaddr, awlen, awsize, awburst);
      werr <= berr(awaddr, awlen, awsize, awburst);
    end else if (w_hs) begin
      waddr <= nxt(waddr, wlen, wsize, wburst);
      wbeat <= wbeat + 8'd1;
      werr <= werr || oob(waddr) || (wlast != (wbeat == wlen));
    end
  end
  always_ff @(posedge aclk)
    if (w_en)
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) mem[waddr[LB +: IW]][i*8 +: 8] <= wdata[i*8 +: 8];
  always_ff @(posedge aclk) rs <= areset ? R_IDLE : rs_n;
  always_comb rs_n = rs == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs && rlast ? R_IDLE : R_DATA);
  always_comb begin
    arready = rs == R_IDLE;
    rvalid = rs == R_DATA;
  end
  // Beat data is prefetched into the output registers, so the RAM read sees pre-write contents
  assign rnext = nxt(raddr, rlen, rsize, rburst);
  assign rsel = ar_hs ? araddr : rnext;
  assign rbad = (ar_hs ? berr(araddr, arlen, arsize, arburst) : rbe) || oob(rsel);
  assign rd_word = mem[rsel[LB +: IW]];
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata <= '0;
      rresp <= '0;
      rlast <= 1'b0;
    end else if (ar_hs) begin
      raddr <= araddr;
      rlen <= arlen;
      rsize <= arsize;
      rburst <= arburst;
      rbeat <= '0;
      rbe <= berr(araddr, arlen, arsize, arburst);
      rdata <= rbad ? '0 : rd_word;
      rresp <= {rbad, 1'b0};
      rlast <= arlen == 8'd0;
    end else if (r_hs && !rlast) begin
      raddr <= rnext;
      rbeat <= rbeat + 8'd1;
      rdata <= rbad ? '0 : rd_word;
      rresp <= {rbad, 1'b0};
      rlast <= rbeat + 8'd1 == rlen;
    end
  end
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// tb_ei_axi4_slave_mem: directed self-checking bench for ei_axi4_slave_mem
module tb_ei_axi4_slave_mem;
  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = 3'd2, arsize = 3'd2;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0] wstrb = '0;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rlast, rvalid, rready = 0;
  int errors = 0, checks = 0;
  logic [31:0] rd_d [16];
  logic [1:0] rd_r [16];
  logic rd_l [16];
  logic [1:0] resp;

  ei_axi4_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] strb, input logic [31:0] d0, input int lastbeat, output logic [1:0] r);
    awaddr = a; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    for (int n = 0; n < 50 && !awready; n++) @(negedge aclk);
    chk("awready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + i; wstrb = strb; wlast = i == lastbeat; wvalid = 1'b1;
      for (int n = 0; n < 50 && !wready; n++) @(negedge aclk);
      chk("wready", wready, 1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    for (int n = 0; n < 50 && !bvalid; n++) @(negedge aclk);
    chk("bvalid", bvalid, 1);
    r = bresp;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) @(negedge aclk);
    chk("arready", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      for (int n = 0; n < 50 && !rvalid; n++) @(negedge aclk);
      chk("rvalid", rvalid, 1);
      rd_d[i] = rdata; rd_r[i] = rresp; rd_l[i] = rlast;
      @(negedge aclk);
    end
    rready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);

    wr(32'h10, 8'd3, 2'd1, 4'hF, 32'hA0, 3, resp);
    chk("incr_bresp", resp, 2'b00);
    rd(32'h10, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rd_d[i], 32'hA0 + i);
      chk("incr_rresp", rd_r[i], 2'b00);
      chk("incr_rlast", rd_l[i], i == 3);
    end

    rd(32'h10, 8'd1, 2'd0);
    chk("fixed_b0", rd_d[0], 32'hA0);
    chk("fixed_b1", rd_d[1], 32'hA0);

    wr(32'h38, 8'd3, 2'd2, 4'hF, 32'hB0, 3, resp);
    chk("wrap_bresp", resp, 2'b00);
    rd(32'h30, 8'd3, 2'd1);
    chk("wrap_30", rd_d[0], 32'hB2);
    chk("wrap_34", rd_d[1], 32'hB3);
    chk("wrap_38", rd_d[2], 32'hB0);
    chk("wrap_3c", rd_d[3], 32'hB1);

    wr(32'h0, 8'd0, 2'd1, 4'hF, 32'h11223344, 0, resp);
    wr(32'h0, 8'd0, 2'd1, 4'b0101, 32'hFFFFFFFF, 0, resp);
    chk("strb_bresp", resp, 2'b00);
    araddr = 32'h0; arlen = 8'd0; arburst = 2'd1; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    repeat (5) begin
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, 32'h11FF33FF);
      @(negedge aclk);
    end
    rready = 1'b1;
    chk("stall_rlast", rlast, 1);
    @(negedge aclk);
    rready = 1'b0;
    chk("stall_done", rvalid, 0);

    wr(32'hFFC, 8'd1, 2'd1, 4'hF, 32'hC0, 1, resp);
    chk("oob_bresp", resp, 2'b10);
    rd(32'hFFC, 8'd1, 2'd1);
    chk("oob_d0", rd_d[0], 32'hC0);
    chk("oob_r0", rd_r[0], 2'b00);
    chk("oob_d1", rd_d[1], 32'h0);
    chk("oob_r1", rd_r[1], 2'b10);

    wr(32'h80, 8'd3, 2'd1, 4'hF, 32'hD0, 1, resp);
    chk("wlast_bresp", resp, 2'b10);
    rd(32'h10, 8'd0, 2'd3);
    chk("rsvd_rresp", rd_r[0], 2'b10);
    chk("rsvd_rdata", rd_d[0], 32'h0);

    araddr = 32'h10; arlen = 8'd7; arburst = 2'd1; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    chk("abort_rvalid_pre", rvalid, 1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("abort_rvalid", rvalid, 0);
    chk("abort_arready", arready, 1);
    chk("abort_rlast", rlast, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
